gen_al_n2w_top: RTL and testbench
=================================

# gen_al_n2w_top

Narrow-to-wide aligner: collects consecutive DAT_IN_W-bit upstream beats into one DAT_OUT_W-bit downstream word, first beat in the least significant lane. It is the counterpart of the wide-to-narrow aligner and restores wide words that were serialized for a narrow path. Each completed word sits in a registered output stage with a valid/ready handshake. An optional early-last mechanism closes a word with fewer lanes and reports the last valid lane index.

## Interface
- DAT_IN_W, 8: upstream (narrow) data width [bits]
- DAT_OUT_W, 32: downstream (wide) data width [bits]; requires DAT_OUT_W % DAT_IN_W == 0 and DAT_OUT_W/DAT_IN_W a power of 2, ≥2
- AL_SEL_W (localparam), $clog2(DAT_OUT_W/DAT_IN_W): lane index width
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous reset, active low
- us_vld  in  1  upstream beat valid
- us_last  in  1  beat closes the current word early (used only with GEN_AL_N2W_LAST_EN)
- us_dat  in  DAT_IN_W  upstream beat data
- us_rdy  out  1  aligner accepts the beat this cycle
- ds_vld  out  1  downstream word valid (registered)
- ds_rdy  in  1  downstream accepts the word
- ds_dat  out  DAT_OUT_W  assembled word (registered)
- ds_last_vld_sel  out  AL_SEL_W  0-based index of the last valid lane in ds_dat (registered)

## Operation
- The aligner accepts a beat when us_vld & us_rdy (acc). us_rdy = ~ds_vld | ds_rdy. us_rdy is combinational from registered ds_vld and input ds_rdy only, never from us_vld or us_last.
- Lane counter wr_sel (AL_SEL_W bits, reset 0). On acc, us_dat is written to lane wr_sel of the assembly register, i.e. bits [wr_sel*DAT_IN_W +: DAT_IN_W].
- A word completes on acc when wr_sel == MAX (MAX = DAT_OUT_W/DAT_IN_W-1), or when us_last=1 and the macro is defined.
- On completion, within the same cycle:
  - ds_dat <= assembly register with the incoming beat merged into lane wr_sel.
  - Lanes above wr_sel are forced to 0.
  - ds_last_vld_sel <= wr_sel; ds_vld <= 1; wr_sel <= 0.
- On a non-completing acc: wr_sel <= wr_sel+1.
- The output stage clears (ds_vld <= 0) when ds_vld & ds_rdy and no completion occurs in the same cycle.
- Drain and completion in the same cycle: the new word replaces the drained one and ds_vld stays 1. This gives back-to-back words with no bubble.
- While ds_vld & ~ds_rdy: ds_dat and ds_last_vld_sel hold stable and us_rdy=0. Partial-word state is not modified.
- The assembly register does not need to be cleared between words; stale lanes are masked at completion.
- Reset mid-word: any partial word and pending output are discarded. No output is produced for them.

## Timing
- Reset values: ds_vld=0, ds_dat=0, ds_last_vld_sel=0, wr_sel=0, assembly register=0. us_rdy evaluates to 1.
- Latency: the completing beat accepted at edge t drives ds_vld=1 from t+1.
- Throughput: one wide word every DAT_OUT_W/DAT_IN_W upstream cycles when ds_rdy is held 1. Upstream is never stalled in that case.
- ds_rdy low for k cycles with ds_vld=1 stalls upstream for exactly those k cycles.

## Configuration
- GEN_AL_N2W_LAST_EN defined:
  - us_last=1 on an accepted beat completes the word at the current lane.
  - ds_last_vld_sel reports that lane.
  - us_last on lane MAX behaves the same as a normal completion.
- GEN_AL_N2W_LAST_EN not defined:
  - us_last is ignored.
  - Words complete only at lane MAX, so ds_last_vld_sel is always MAX.
  - The port list is unchanged.

## Test plan
- Defaults, ds_rdy=1, beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after the 4th beat: ds_vld=1, ds_dat=0x44332211, ds_last_vld_sel=3. us_rdy stays 1 throughout.
- Continuous beats 0x01..0x08, ds_rdy=1 -> 0x04030201 then 0x08070605, each valid for one cycle, no upstream stall.
- Word 0xDDCCBBAA completes, ds_rdy=0 for 3 cycles -> ds_dat holds, us_rdy=0 for 3 cycles, next beat accepted in the cycle ds_rdy returns to 1.
- LAST_EN: beats 0xAA,0xBB with us_last=1 on 0xBB -> ds_dat=0x0000BBAA, ds_last_vld_sel=1. The next beat lands in lane 0.
- Without LAST_EN: same stimulus -> no output until 2 more beats arrive, then ds_last_vld_sel=3.
- Assert rst_n=0 after 2 of 4 beats, with a stalled word pending -> ds_vld=0 immediately. After release, 4 new beats produce exactly one word with only the new data.

Source files
------------

// File: rtl/gen_al_n2w_top.sv
// Narrow-to-wide aligner: packs DAT_IN_W-bit beats (first beat in lane 0) into a registered DAT_OUT_W-bit word.
// Optional early-last closing of a word is enabled by defining GEN_AL_N2W_LAST_EN.
module gen_al_n2w_top #(
  parameter int unsigned DAT_IN_W  = 8,
  parameter int unsigned DAT_OUT_W = 32,
  localparam int unsigned AL_SEL_W = $clog2(DAT_OUT_W / DAT_IN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 us_vld,
  input  logic                 us_last,
  input  logic [DAT_IN_W-1:0]  us_dat,
  output logic                 us_rdy,
  output logic                 ds_vld,
  input  logic                 ds_rdy,
  output logic [DAT_OUT_W-1:0] ds_dat,
  output logic [AL_SEL_W-1:0]  ds_last_vld_sel
);

  localparam int unsigned NLANE = DAT_OUT_W / DAT_IN_W;
  localparam logic [AL_SEL_W-1:0] SEL_MAX = AL_SEL_W'(NLANE - 1);

  logic [AL_SEL_W-1:0]  wr_sel_q, wr_sel_d;
  logic [DAT_OUT_W-1:0] asm_q, asm_d;
  logic [DAT_OUT_W-1:0] ds_dat_q, ds_dat_d;
  logic [AL_SEL_W-1:0]  ds_sel_q, ds_sel_d;
  logic                 ds_vld_q, ds_vld_d;
  logic [DAT_OUT_W-1:0] merged;
  logic                 acc, last_hit, cmpl;

  assign us_rdy = ~ds_vld_q | ds_rdy;
  assign acc    = us_vld & us_rdy;

`ifdef GEN_AL_N2W_LAST_EN
  assign last_hit = us_last;
`else
  logic unused_last;
  assign last_hit    = 1'b0;
  assign unused_last = us_last;
`endif

  assign cmpl = acc & ((wr_sel_q == SEL_MAX) | last_hit);

  // Lanes below wr_sel come from the assembly register, the current lane from
  // the incoming beat, and lanes above are zeroed so stale data never leaks out.
  always_comb begin
    asm_d  = asm_q;
    merged = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (i == 32'(wr_sel_q)) begin
        merged[i*DAT_IN_W +: DAT_IN_W] = us_dat;
        if (acc) asm_d[i*DAT_IN_W +: DAT_IN_W] = us_dat;
      end else if (i < 32'(wr_sel_q)) begin
        merged[i*DAT_IN_W +: DAT_IN_W] = asm_q[i*DAT_IN_W +: DAT_IN_W];
      end
    end
  end

  // Completion takes priority over drain, giving bubble-free back-to-back words.
  always_comb begin
    wr_sel_d = wr_sel_q;
    ds_dat_d = ds_dat_q;
    ds_sel_d = ds_sel_q;
    ds_vld_d = ds_vld_q;
    if (cmpl) begin
      ds_dat_d = merged;
      ds_sel_d = wr_sel_q;
      ds_vld_d = 1'b1;
      wr_sel_d = '0;
    end else begin
      if (acc) wr_sel_d = wr_sel_q + AL_SEL_W'(1);
      if (ds_vld_q & ds_rdy) ds_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= '0;
      asm_q    <= '0;
      ds_dat_q <= '0;
      ds_sel_q <= '0;
      ds_vld_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      asm_q    <= asm_d;
      ds_dat_q <= ds_dat_d;
      ds_sel_q <= ds_sel_d;
      ds_vld_q <= ds_vld_d;
    end
  end

  assign ds_vld          = ds_vld_q;
  assign ds_dat          = ds_dat_q;
  assign ds_last_vld_sel = ds_sel_q;

endmodule

// File: tb/tb_gen_al_n2w_top.sv
// Directed self-checking bench for gen_al_n2w_top (default 8->32 configuration).
// Follows GEN_AL_N2W_LAST_EN to select the expected early-last behaviour.
module tb_gen_al_n2w_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        us_vld, us_last, us_rdy;
  logic [7:0]  us_dat;
  logic        ds_vld, ds_rdy;
  logic [31:0] ds_dat;
  logic [1:0]  ds_last_vld_sel;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  gen_al_n2w_top #(.DAT_IN_W(8), .DAT_OUT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .us_vld          (us_vld),
    .us_last         (us_last),
    .us_dat          (us_dat),
    .us_rdy          (us_rdy),
    .ds_vld          (ds_vld),
    .ds_rdy          (ds_rdy),
    .ds_dat          (ds_dat),
    .ds_last_vld_sel (ds_last_vld_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, confirm it is accepted, and advance past its clock edge.
  task automatic send(input logic [7:0] d, input logic last);
    us_vld  = 1'b1;
    us_dat  = d;
    us_last = last;
    #1 chk("us_rdy_on_beat", us_rdy, 1'b1);
    @(posedge clk);
    #1;
    us_vld  = 1'b0;
    us_last = 1'b0;
  endtask

  logic [7:0] t1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst_n = 1'b0; us_vld = 1'b0; us_last = 1'b0; us_dat = '0; ds_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ds_vld", ds_vld, 1'b0);
    chk("rst_ds_dat", ds_dat, 32'h0);
    chk("rst_sel", ds_last_vld_sel, 2'd0);
    chk("rst_us_rdy", us_rdy, 1'b1);
    rst_n = 1'b1;
    step();

    // Single word
    for (int i = 0; i < 4; i++) begin
      send(t1[i], 1'b0);
      chk("t1_vld", ds_vld, (i == 3));
    end
    chk("t1_dat", ds_dat, 32'h44332211);
    chk("t1_sel", ds_last_vld_sel, 2'd3);
    step();
    chk("t1_drain", ds_vld, 1'b0);

    // Continuous beats, two words back to back
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0);
      chk("t2_vld", ds_vld, (i % 4 == 0));
      if (i == 4) chk("t2_dat0", ds_dat, 32'h04030201);
      if (i == 8) chk("t2_dat1", ds_dat, 32'h08070605);
    end
    step();

    // Downstream stall for 3 cycles
    ds_rdy = 1'b0;
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    chk("t3_vld", ds_vld, 1'b1);
    chk("t3_dat", ds_dat, 32'hDDCCBBAA);
    us_vld = 1'b1; us_dat = 8'h55;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t3_stall_rdy", us_rdy, 1'b0);
      step();
      chk("t3_hold_dat", ds_dat, 32'hDDCCBBAA);
      chk("t3_hold_vld", ds_vld, 1'b1);
    end
    ds_rdy = 1'b1;
    send(8'h55, 1'b0);
    chk("t3_drained", ds_vld, 1'b0);
    send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    chk("t3_next_dat", ds_dat, 32'h88776655);
    chk("t3_next_vld", ds_vld, 1'b1);
    step();

    // Early last on lane 1
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
`ifdef GEN_AL_N2W_LAST_EN
    chk("t4_vld", ds_vld, 1'b1);
    chk("t4_dat", ds_dat, 32'h0000BBAA);
    chk("t4_sel", ds_last_vld_sel, 2'd1);
    send(8'h01, 1'b0);
    chk("t4_vld_after", ds_vld, 1'b0);
    send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("t4_next_dat", ds_dat, 32'h04030201);
    chk("t4_next_sel", ds_last_vld_sel, 2'd3);
`else
    chk("t4_no_early", ds_vld, 1'b0);
    send(8'hCC, 1'b0);
    chk("t4_no_early2", ds_vld, 1'b0);
    send(8'hDD, 1'b0);
    chk("t4_vld", ds_vld, 1'b1);
    chk("t4_dat", ds_dat, 32'hDDCCBBAA);
    chk("t4_sel", ds_last_vld_sel, 2'd3);
`endif
    step();

    // Reset with a stalled word pending
    ds_rdy = 1'b0;
    send(8'h10, 1'b0); send(8'h11, 1'b0); send(8'h12, 1'b0); send(8'h13, 1'b0);
    chk("t5_pending", ds_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_vld", ds_vld, 1'b0);
    chk("t5_async_dat", ds_dat, 32'h0);
    chk("t5_async_rdy", us_rdy, 1'b1);
    step();
    rst_n = 1'b1;
    ds_rdy = 1'b1;

    // Reset after 2 of 4 beats discards the partial word
    send(8'h21, 1'b0); send(8'h22, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send(8'h31, 1'b0);
    chk("t6_vld_a", ds_vld, 1'b0);
    send(8'h32, 1'b0);
    chk("t6_vld_b", ds_vld, 1'b0);
    send(8'h33, 1'b0);
    chk("t6_vld_c", ds_vld, 1'b0);
    send(8'h34, 1'b0);
    chk("t6_vld", ds_vld, 1'b1);
    chk("t6_dat", ds_dat, 32'h34333231);
    chk("t6_sel", ds_last_vld_sel, 2'd3);
    step();
    chk("t6_single", ds_vld, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
